// File: rtl/hazard_unit.sv
// Load-use hazard detection, memory-busy freeze and taken-branch flush control
// for a five-stage pipeline, plus a saturating count of stall cycles.
module hazard_unit #(
  parameter int ADDR_W   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_i,
  input  logic [ADDR_W-1:0] rs2_i,
  input  logic              rs1_used_i,
  input  logic              rs2_used_i,
  input  logic [ADDR_W-1:0] rd_i,
  input  logic              ctrlMemRead_i,
  input  logic              branch_taken_i,
  input  logic              dmem_busy_i,
  input  logic              stat_clr_i,
  output logic              ctrlPcWrite_o,
  output logic              stall_o,
  output logic              noop_o,
  output logic              flush_o,
  output logic              freeze_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic {IDLE = 1'b0, LOAD_STALL = 1'b1} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LOAD_LAT - 1);

  // state_q and rem_q are the observable FSM state for checkers.
  state_t     state_q, state_n;
  logic [3:0] rem_q, rem_n;
  logic       hit;
  logic [CNT_W-1:0] cnt_q;

  assign hit = ctrlMemRead_i && (rd_i != '0) &&
               ((rs1_used_i && (rs1_i == rd_i)) || (rs2_used_i && (rs2_i == rd_i)));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= 4'd0;
    end else begin
      state_q <= state_n;
      rem_q   <= rem_n;
    end
  end

  // Busy outranks everything and holds the FSM; LOAD_STALL ignores hit.
  always_comb begin
    state_n       = state_q;
    rem_n         = rem_q;
    ctrlPcWrite_o = 1'b1;
    stall_o       = 1'b0;
    noop_o        = 1'b0;
    freeze_o      = 1'b0;
    if (rst_i) begin
      ctrlPcWrite_o = 1'b0;
    end else if (dmem_busy_i) begin
      ctrlPcWrite_o = 1'b0;
      stall_o       = 1'b1;
      freeze_o      = 1'b1;
    end else if (state_q == LOAD_STALL) begin
      ctrlPcWrite_o = 1'b0;
      stall_o       = 1'b1;
      noop_o        = 1'b1;
      rem_n         = rem_q - 4'd1;
      if (rem_q == 4'd1) state_n = IDLE;
    end else if (hit) begin
      ctrlPcWrite_o = 1'b0;
      stall_o       = 1'b1;
      noop_o        = 1'b1;
      if (LOAD_LAT > 1) begin
        state_n = LOAD_STALL;
        rem_n   = LAT_M1;
      end
    end
  end

  // A branch seen during a stall is dropped; ID re-presents it afterwards.
  assign flush_o = branch_taken_i & ~stall_o & ~dmem_busy_i & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (stat_clr_i) begin
      cnt_q <= '0;
    end else if (stall_o && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: one instance with LOAD_LAT=1, one with
// LOAD_LAT=3 and a 3-bit stall counter, both driven from shared inputs.
module tb_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs1, rs2, rd;
  logic       rs1_used, rs2_used, mem_read, branch, busy, clr;

  logic        pc1, st1, nop1, fl1, fz1;
  logic [31:0] cnt1;
  logic        pc3, st3, nop3, fl3, fz3;
  logic [2:0]  cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_unit #(.ADDR_W(5), .LOAD_LAT(1), .CNT_W(32)) u1 (
    .clk_i(clk), .rst_i(rst), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_i(rd),
    .ctrlMemRead_i(mem_read), .branch_taken_i(branch), .dmem_busy_i(busy),
    .stat_clr_i(clr), .ctrlPcWrite_o(pc1), .stall_o(st1), .noop_o(nop1),
    .flush_o(fl1), .freeze_o(fz1), .stall_cnt_o(cnt1)
  );

  hazard_unit #(.ADDR_W(5), .LOAD_LAT(3), .CNT_W(3)) u3 (
    .clk_i(clk), .rst_i(rst), .rs1_i(rs1), .rs2_i(rs2),
    .rs1_used_i(rs1_used), .rs2_used_i(rs2_used), .rd_i(rd),
    .ctrlMemRead_i(mem_read), .branch_taken_i(branch), .dmem_busy_i(busy),
    .stat_clr_i(clr), .ctrlPcWrite_o(pc3), .stall_o(st3), .noop_o(nop3),
    .flush_o(fl3), .freeze_o(fz3), .stall_cnt_o(cnt3)
  );

  // Output vector order: {ctrlPcWrite, stall, noop, flush, freeze}
  logic [4:0] o1, o3;
  assign o1 = {pc1, st1, nop1, fl1, fz1};
  assign o3 = {pc3, st3, nop3, fl3, fz3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; mem_read = 1'b0;
    branch = 1'b0; busy = 1'b0; clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    #3;
    chk("reset_outs_u1", 32'(o1), 32'(5'b00000));
    chk("reset_outs_u3", 32'(o3), 32'(5'b00000));
    chk("reset_cnt_u1", cnt1, 32'd0);
    chk("reset_rem_u3", 32'(u3.rem_q), 32'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("idle_outs_u1", 32'(o1), 32'(5'b10000));

    // Scenario 1: single-cycle load-use stall
    mem_read = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
    settle();
    chk("s1_stall", 32'(o1), 32'(5'b01100));
    cyc();
    idle_inputs();
    settle();
    chk("s1_release", 32'(o1), 32'(5'b10000));
    chk("s1_cnt", cnt1, 32'd1);

    // Scenario 2: x0 and unused operand never stall
    do_reset();
    mem_read = 1'b1; rd = 5'd0; rs1 = 5'd0; rs1_used = 1'b1;
    settle();
    chk("s2_x0_u1", 32'(o1), 32'(5'b10000));
    chk("s2_x0_u3", 32'(o3), 32'(5'b10000));
    rd = 5'd7; rs2 = 5'd7; rs2_used = 1'b0; rs1 = 5'd3;
    settle();
    chk("s2_unused_u1", 32'(o1), 32'(5'b10000));
    chk("s2_unused_u3", 32'(o3), 32'(5'b10000));
    rs2_used = 1'b1;
    settle();
    chk("s2_rs2_hit", 32'(o1), 32'(5'b01100));
    cyc();

    // Scenario 3: LOAD_LAT=3 with two busy cycles inside the stall
    do_reset();
    mem_read = 1'b1; rd = 5'd9; rs2 = 5'd9; rs2_used = 1'b1;
    settle();
    chk("s3_a_stall", 32'(o3), 32'(5'b01100));
    cyc();
    idle_inputs();
    busy = 1'b1;
    settle();
    chk("s3_b_freeze", 32'(o3), 32'(5'b01001));
    chk("s3_b_rem", 32'(u3.rem_q), 32'd2);
    cyc();
    mem_read = 1'b1; rd = 5'd4; rs1 = 5'd4; rs1_used = 1'b1;
    settle();
    chk("s3_c_freeze", 32'(o3), 32'(5'b01001));
    chk("s3_c_rem", 32'(u3.rem_q), 32'd2);
    cyc();
    idle_inputs();
    settle();
    chk("s3_d_stall", 32'(o3), 32'(5'b01100));
    chk("s3_d_rem", 32'(u3.rem_q), 32'd2);
    cyc();
    settle();
    chk("s3_e_stall", 32'(o3), 32'(5'b01100));
    chk("s3_e_rem", 32'(u3.rem_q), 32'd1);
    cyc();
    settle();
    chk("s3_f_release", 32'(o3), 32'(5'b10000));
    chk("s3_cnt", 32'(cnt3), 32'd5);

    // Scenario 4: taken branch against a hazard and against busy
    do_reset();
    mem_read = 1'b1; rd = 5'd2; rs1 = 5'd2; rs1_used = 1'b1; branch = 1'b1;
    settle();
    chk("s4_branch_in_stall", 32'(o1), 32'(5'b01100));
    cyc();
    mem_read = 1'b0;
    settle();
    chk("s4_branch_flush", 32'(o1), 32'(5'b10010));
    busy = 1'b1;
    settle();
    chk("s4_branch_busy", 32'(o1), 32'(5'b01001));
    cyc();

    // Scenario 5: 3-bit counter saturates, clear wins over increment
    do_reset();
    busy = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      cyc();
      chk($sformatf("s5_sat_%0d", i), 32'(cnt3), (i > 7) ? 32'd7 : 32'(i));
    end
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    settle();
    chk("s5_clear", 32'(cnt3), 32'd0);
    cyc();
    chk("s5_after_clear", 32'(cnt3), 32'd1);

    // Scenario 6: reset pulsed mid LOAD_STALL
    do_reset();
    mem_read = 1'b1; rd = 5'd6; rs1 = 5'd6; rs1_used = 1'b1;
    cyc();
    idle_inputs();
    settle();
    chk("s6_in_stall", 32'(o3), 32'(5'b01100));
    chk("s6_rem2", 32'(u3.rem_q), 32'd2);
    rst = 1'b1;
    settle();
    chk("s6_rst_outs", 32'(o3), 32'(5'b00000));
    chk("s6_rst_rem", 32'(u3.rem_q), 32'd0);
    chk("s6_rst_cnt", 32'(cnt3), 32'd0);
    cyc();
    rst = 1'b0;
    settle();
    chk("s6_release", 32'(o3), 32'(5'b10000));
    cyc();
    chk("s6_idle_next", 32'(o3), 32'(5'b10000));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
